// File: rtl/seg_timer_pkg.sv
// Shared types and constants for the segment stopwatch/countdown.
// FSM state encoding, seven-segment glyph constants and the nibble decoder.
// No logic of its own; imported by seg7_scan and seg_timer_mux.
package seg_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // BCD nibble to active-high segments; anything above 9 shows nothing
    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: steps one digit per scan slot and drives segments/enables.
// Latency: outputs registered one cycle from (scan index, display value).
// No backpressure; free-running from reset release.
module seg7_scan
    import seg_timer_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 10_000,
    parameter int SEG_ACT_LOW = 0,
    parameter int DIG_ACT_LOW = 0,
    parameter int LZ_BLANK    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] disp,
    output logic [6:0]              seven_seg,
    output logic [NUM_DIGITS-1:0]   digit_en
);

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SLOT_W-1:0]     SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    // Polarity masks are folded in only at the output registers
    localparam logic [6:0]            SEG_XOR   = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] DIG_XOR   = {NUM_DIGITS{(DIG_ACT_LOW != 0)}};

    logic [SLOT_W-1:0]     slot;
    logic [IDX_W-1:0]      idx;
    logic [3:0]            nib;
    logic                  upper_zero;
    logic                  blank;
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] dig_raw;

    // Slot timer; the digit index advances when a slot expires
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
            idx  <= '0;
        end else if (slot == SLOT_LAST) begin
            slot <= '0;
            idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    // Select the current digit and decide leading-zero blanking
    always_comb begin
        nib        = 4'd0;
        upper_zero = 1'b1;
        dig_raw    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && disp[4*k +: 4] != 4'd0) upper_zero = 1'b0;
            if (k == int'(idx)) begin
                nib        = disp[4*k +: 4];
                dig_raw[k] = 1'b1;
            end
        end
        // Digit 0 always shows, so a zero count still reads "0"
        blank   = (LZ_BLANK != 0) && (idx != '0) && upper_zero;
        seg_raw = blank ? SEG_BLANK : seg7_decode(nib);
    end

    // Output registers with polarity applied; reset leaves everything dark
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seven_seg <= SEG_XOR;
            digit_en  <= DIG_XOR;
        end else begin
            seven_seg <= seg_raw ^ SEG_XOR;
            digit_en  <= dig_raw ^ DIG_XOR;
        end
    end

endmodule

// File: rtl/seg_timer_mux.sv
// BCD stopwatch/countdown with run/pause/clear, display hold and scanned 7-segment output.
// Latency: button action on the 3rd clock edge after the pin rises; count/running one cycle after event.
// No backpressure; pad inputs are sampled every cycle, display free-runs.
module seg_timer_mux
    import seg_timer_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 10_000_000,
    parameter int SCAN_DIV    = 10_000,
    parameter int SEG_ACT_LOW = 0,
    parameter int DIG_ACT_LOW = 0,
    parameter int LZ_BLANK    = 1
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic                    clear_i,
    input  logic                    dir_i,
    input  logic                    hold_i,
    output logic [6:0]              seven_seg,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic                    running_o,
    output logic                    wrap_o
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    // pin vector order {hold, dir, clear, stop, start}
    logic [4:0] pin_s1;
    logic [4:0] pin_s2;
    logic [2:0] btn_prev;
    logic [2:0] btn_rise;
    logic       start_ev;
    logic       stop_ev;
    logic       clear_ev;
    logic       dir_s;
    logic       hold_s;

    state_t                  state;
    logic [PRE_W-1:0]        presc;
    logic [4*NUM_DIGITS-1:0] count_q;
    logic [4*NUM_DIGITS-1:0] disp_latch;
    logic                    running_q;
    logic                    wrap_q;

    logic [4*NUM_DIGITS-1:0] cnt_inc;
    logic [4*NUM_DIGITS-1:0] cnt_dec;
    logic                    carry;
    logic                    borrow;

    // Two-flop synchronisers for all pads, plus previous value for button edges
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            pin_s1   <= '0;
            pin_s2   <= '0;
            btn_prev <= '0;
        end else begin
            pin_s1   <= {hold_i, dir_i, clear_i, stop_i, start_i};
            pin_s2   <= pin_s1;
            btn_prev <= pin_s2[2:0];
        end
    end

    assign btn_rise = pin_s2[2:0] & ~btn_prev;
    assign start_ev = btn_rise[0];
    assign stop_ev  = btn_rise[1];
    assign clear_ev = btn_rise[2];
    assign dir_s    = pin_s2[3];
    assign hold_s   = pin_s2[4];

    // Next count values for both directions; final carry/borrow flags the wrap
    always_comb begin
        cnt_inc = count_q;
        cnt_dec = count_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (carry) begin
                if (cnt_inc[4*k +: 4] == 4'd9) begin
                    cnt_inc[4*k +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*k +: 4] = cnt_inc[4*k +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (cnt_dec[4*k +: 4] == 4'd0) begin
                    cnt_dec[4*k +: 4] = 4'd9;
                end else begin
                    cnt_dec[4*k +: 4] = cnt_dec[4*k +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

    // Control FSM with prescaler and counter; stop freezes the prescaler mid-period
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= ST_IDLE;
            presc     <= '0;
            count_q   <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (clear_ev) begin
                state     <= ST_IDLE;
                presc     <= '0;
                count_q   <= '0;
                running_q <= 1'b0;
            end else if (stop_ev && state == ST_RUN) begin
                state     <= ST_PAUSE;
                running_q <= 1'b0;
            end else if (start_ev && state != ST_RUN) begin
                if (state == ST_IDLE) presc <= '0;
                state     <= ST_RUN;
                running_q <= 1'b1;
            end else if (state == ST_RUN) begin
                if (presc == PRE_LAST) begin
                    presc   <= '0;
                    count_q <= dir_s ? cnt_dec : cnt_inc;
                    wrap_q  <= dir_s ? borrow : carry;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

    // Display latch follows the count unless the user is holding the reading
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            disp_latch <= '0;
        end else if (!hold_s) begin
            disp_latch <= count_q;
        end
    end

    assign count_o   = count_q;
    assign running_o = running_q;
    assign wrap_o    = wrap_q;

    seg7_scan #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .SEG_ACT_LOW (SEG_ACT_LOW),
        .DIG_ACT_LOW (DIG_ACT_LOW),
        .LZ_BLANK    (LZ_BLANK)
    ) u_scan (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_ni),
        .disp      (disp_latch),
        .seven_seg (seven_seg),
        .digit_en  (digit_en)
    );

endmodule

// File: tb/tb_seg_timer_mux.sv
// Bench for seg_timer_mux: two instances (active-high and active-low outputs) share stimulus.
// A decimal reference model predicts every clock edge; a monitor compares on the falling edge.
// Directed phases cover carry, wrap both ways, pause/resume, clear priority, hold and reset.
module tb_seg_timer_mux;

    localparam int ND  = 2;
    localparam int TD  = 4;
    localparam int SD  = 2;
    localparam int MOD = 100;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    typedef struct {
        logic [6:0] seg;
        logic [1:0] dig;
        logic [7:0] cnt;
        logic       run;
        logic       wrap;
        string      tag;
    } exp_t;

    logic clk, rst_n;
    logic start, stop, clear, dir, hold;
    logic [6:0] seg_a, seg_b;
    logic [1:0] dig_a, dig_b;
    logic [7:0] cnt_a, cnt_b;
    logic run_a, run_b, wrap_a, wrap_b;

    exp_t  exp_q[$];
    int    n_pass = 0;
    int    n_total = 0;
    string phase = "reset";

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // reference model state (decimal count)
    int m_state, m_presc, m_count, m_latch, m_k;
    bit [3:0] h_start, h_stop, h_clear, h_dir, h_hold;

    seg_timer_mux #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD),
                    .SEG_ACT_LOW(0), .DIG_ACT_LOW(0), .LZ_BLANK(1)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .stop_i(stop),
        .clear_i(clear), .dir_i(dir), .hold_i(hold), .seven_seg(seg_a),
        .digit_en(dig_a), .count_o(cnt_a), .running_o(run_a), .wrap_o(wrap_a));

    seg_timer_mux #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD),
                    .SEG_ACT_LOW(1), .DIG_ACT_LOW(1), .LZ_BLANK(1)) dut_inv (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .stop_i(stop),
        .clear_i(clear), .dir_i(dir), .hold_i(hold), .seven_seg(seg_b),
        .digit_en(dig_b), .count_o(cnt_b), .running_o(run_b), .wrap_o(wrap_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'((v / 10) % 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic int pow10(input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    task automatic model_reset();
        m_state = M_IDLE; m_presc = 0; m_count = 0; m_latch = 0; m_k = 0;
        h_start = '0; h_stop = '0; h_clear = '0; h_dir = '0; h_hold = '0;
    endtask

    // Predict the outputs visible after the clock edge that just occurred
    task automatic model_edge();
        int   idx, upper, old_count, old_latch;
        bit   sta, stp, clr, d, hd, wrp;
        exp_t e;
        m_k++;
        h_start = {h_start[2:0], start};
        h_stop  = {h_stop[2:0],  stop};
        h_clear = {h_clear[2:0], clear};
        h_dir   = {h_dir[2:0],   dir};
        h_hold  = {h_hold[2:0],  hold};
        // a pin level seen at edge k-2 acts at edge k; a rise needs it low at k-3
        sta = h_start[2] & ~h_start[3];
        stp = h_stop[2]  & ~h_stop[3];
        clr = h_clear[2] & ~h_clear[3];
        d   = h_dir[2];
        hd  = h_hold[2];
        old_count = m_count;
        old_latch = m_latch;
        wrp = 1'b0;
        if (clr) begin
            m_state = M_IDLE; m_count = 0; m_presc = 0;
        end else if (stp && m_state == M_RUN) begin
            m_state = M_PAUSE;
        end else if (sta && m_state != M_RUN) begin
            if (m_state == M_IDLE) m_presc = 0;
            m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            if (m_presc == TD - 1) begin
                m_presc = 0;
                if (d) begin
                    wrp = (m_count == 0);
                    m_count = (m_count + MOD - 1) % MOD;
                end else begin
                    wrp = (m_count == MOD - 1);
                    m_count = (m_count + 1) % MOD;
                end
            end else begin
                m_presc++;
            end
        end
        if (!hd) m_latch = old_count;
        idx   = ((m_k - 1) / SD) % ND;
        upper = old_latch / pow10(idx);
        e.seg  = (idx > 0 && upper == 0) ? 7'h00 : seg_tab[upper % 10];
        e.dig  = 2'(1 << idx);
        e.cnt  = to_bcd(m_count);
        e.run  = (m_state == M_RUN);
        e.wrap = wrp;
        e.tag  = phase;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            model_edge();
        end
    endtask

    // Assert reset away from the edge, queue the reset-state expectation, release
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        start = 0; stop = 0; clear = 0; dir = 0; hold = 0;
        model_reset();
        e.seg = 7'h00; e.dig = 2'b00; e.cnt = 8'h00; e.run = 1'b0; e.wrap = 1'b0;
        e.tag = "in_reset";
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s %s: got %0h expected %0h", tag, name, act, expv);
    endtask

    // Monitor: one expected record per clock edge, compared mid-cycle
    initial begin
        exp_t e;
        logic [6:0] inv_seg;
        logic [1:0] inv_dig;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                inv_seg = ~e.seg;
                inv_dig = ~e.dig;
                chk(e.tag, "count_o",     32'(cnt_a),  32'(e.cnt));
                chk(e.tag, "running_o",   32'(run_a),  32'(e.run));
                chk(e.tag, "wrap_o",      32'(wrap_a), 32'(e.wrap));
                chk(e.tag, "seven_seg",   32'(seg_a),  32'(e.seg));
                chk(e.tag, "digit_en",    32'(dig_a),  32'(e.dig));
                chk(e.tag, "seg_actlow",  32'(seg_b),  32'(inv_seg));
                chk(e.tag, "dig_actlow",  32'(dig_b),  32'(inv_dig));
                chk(e.tag, "count_inv",   32'(cnt_b),  32'(e.cnt));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 0; stop = 0; clear = 0; dir = 0; hold = 0;
        model_reset();
        do_reset();
        phase = "idle";
        cyc(4);

        phase = "count_up";
        start = 1; cyc(1); start = 0;
        cyc(44);

        phase = "wrap_up";
        cyc(400);

        phase = "wrap_down";
        dir = 1;
        cyc(80);
        dir = 0;

        phase = "pause_resume";
        stop = 1; cyc(1); stop = 0;
        cyc(6);
        start = 1; cyc(1); start = 0;
        cyc(14);
        start = 1; cyc(1); start = 0;
        cyc(12);

        phase = "clear_start";
        clear = 1; start = 1; cyc(1); clear = 0; start = 0;
        cyc(8);

        phase = "hold";
        start = 1; cyc(1); start = 0;
        cyc(6);
        hold = 1; cyc(30); hold = 0;
        cyc(10);

        phase = "lz_blank";
        clear = 1; cyc(1); clear = 0;
        cyc(4);
        start = 1; cyc(1); start = 0;
        cyc(26);

        phase = "reset_midrun";
        do_reset();
        cyc(4);

        phase = "random";
        start = 1; cyc(1); start = 0;
        for (int i = 0; i < 1500; i++) begin
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 39) == 0);
            clear = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 99) == 0) dir = ~dir;
            if ($urandom_range(0, 63) == 0) hold = ~hold;
            cyc(1);
        end
        start = 0; stop = 0; clear = 0;
        cyc(4);

        @(negedge clk);
        #1;
        chk("end", "queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
